cpu_debug_ctl: RTL and testbench
================================

# cpu_debug_ctl

Run/halt controller and register-dump sequencer that sits between the top-level harness and `cpu`. It starts the CPU, counts executed cycles and stops on `halted` or on a programmable watchdog timeout. It then snapshots the full register file and streams it out one register per transfer over a valid/ready handshake. It generalises the fixed run-until-halted loop: register count, register width and cycle-counter width are parametrised, and it adds timeout, restart and back-pressured register dumping.

## Interface
Parameters:
- `REG_WIDTH`, default `` `RegWidth `` (16): width of one CPU register.
- `NUM_REGS`, default `` `NumRegs `` (8): number of registers dumped; must be ≥1.
- `CYC_WIDTH`, default 32: width of the cycle counter.
- `MAX_CYCLES`, default 100000: watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- `halted`  in  1  CPU halt indication.
- `reg_state`  in  NUM_REGS*REG_WIDTH  flattened register file; register i occupies bits [i*REG_WIDTH +: REG_WIDTH].
- `run`  out  1  CPU clock-enable.
- `cycle_count`  out  CYC_WIDTH  RUN cycles elapsed in the current or last run.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  consumer accepts the word.
- `dump_idx`  out  $clog2(NUM_REGS) (min 1)  register index of `dump_data`.
- `dump_data`  out  REG_WIDTH  snapshot value of register `dump_idx`.
- `done`  out  1  run and dump complete.
- `timeout`  out  1  last run ended by the watchdog, not by `halted`.

## Operation
- FSM states and transitions:
  - IDLE: `start` → RUN.
  - RUN: `halted` → DUMP; watchdog expiry → DUMP with `timeout` set.
  - DUMP: last register accepted → DONE.
  - DONE: `start` → RUN.
- Reset values: state IDLE; `run`, `dump_valid`, `done` and `timeout` are 0; `cycle_count`, `dump_idx` and `dump_data` are 0.
- On the edge that accepts `start` (IDLE→RUN or DONE→RUN):
  - `cycle_count` is cleared to 0.
  - `timeout` and `done` are cleared.
- RUN:
  - `run`=1.
  - `cycle_count` increments by 1 per cycle and saturates at all-ones, with no wrap.
  - `halted` is sampled every cycle.
- Watchdog expiry: in RUN with `cycle_count == MAX_CYCLES-1`, `halted`=0 and `MAX_CYCLES != 0`.
- If `halted` and expiry occur in the same cycle, `halted` wins and `timeout` stays 0.
- `halted` already high on the first RUN cycle ends the run with `cycle_count`=1.
- On the RUN→DUMP edge:
  - All of `reg_state` is captured into an internal snapshot.
  - `run` drops.
  - `dump_idx` is set to 0.
- DUMP: `dump_valid`=1.
  - `dump_data` = snapshot[`dump_idx`].
  - A transfer occurs when `dump_valid & dump_ready`; `dump_idx` then increments.
  - When `dump_ready`=0, `dump_idx` and `dump_data` hold stable.
  - The transfer at `dump_idx == NUM_REGS-1` moves the FSM to DONE; `dump_valid` is 0 on the next cycle.
- DONE: `done`=1. `cycle_count`, `timeout` and the last `dump_idx` hold until the next accepted `start`.
- `start` in RUN or DUMP is ignored.
- `RST_N`=0 in any state returns to reset values on that edge; a dump in progress is abandoned with no further `dump_valid`.

## Timing
- `start` accepted at edge N gives `run`=1 from N to N+1.
- `halted` sampled at edge M: `run`=0 and `dump_valid`=1 after M.
- With `dump_ready` held at 1, DUMP lasts exactly NUM_REGS cycles; `done` rises NUM_REGS cycles after DUMP entry.
- All outputs are registered; there are no combinational paths from `dump_ready` or `halted` to outputs.

## Configuration
- `CPU_DEBUG_DUMP_EN` defined:
  - Snapshot storage and DUMP state are present, as specified above.
- `CPU_DEBUG_DUMP_EN` undefined:
  - No snapshot storage and no DUMP state.
  - RUN goes directly to DONE on halt or expiry.
  - `dump_valid`, `dump_idx` and `dump_data` are tied to 0.
  - `dump_ready` is ignored.

## Structure
- Shared package `cpu_debug_pkg`:
  - state enum `dbg_state_t` {IDLE, RUN, DUMP, DONE}.
  - helper constant for the index width.
- `RegWidth` and `NumRegs` defaults come from `defs.svh`.
- Sub-module `cpu_dump_scan`: snapshot register bank plus index counter with valid/ready output. The top holds the FSM and the watchdog.

## Test plan
- Halt after 10 cycles, NUM_REGS=8, `dump_ready`=1, regs = i*0x11:
  - `cycle_count`=10, `timeout`=0.
  - Eight transfers with idx 0..7 and data 0x00..0x77 on consecutive cycles.
  - `done`=1.
- MAX_CYCLES=20, `halted` never asserted: `run` high for exactly 20 cycles, `timeout`=1, full dump follows.
- `halted` rises on the cycle where `cycle_count`=19 with MAX_CYCLES=20: `timeout`=0.
- `dump_ready` toggling 1,0,0,1, with `reg_state` changed during DUMP: data/idx hold while ready=0; the dumped values equal the halt-time snapshot.
- `RST_N`=0 at dump idx 3: next cycle `dump_valid`=0, state IDLE.
- After `done`, `start` again: `cycle_count` restarts at 0 and a second dump completes. `start` pulsed during RUN has no effect.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared types and helpers for the CPU debug controller.
// Register-file defaults RegWidth/NumRegs may be overridden with +define on the command line.
`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef NumRegs
`define NumRegs 8
`endif

package cpu_debug_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } dbg_state_t;

  // Index width for a register count; a single register still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_debug_ctl_if.sv
// Register-dump stream between the debug controller (master) and its consumer (slave).
// Handshake: a word moves on every rising edge where dump_valid & dump_ready; while
// dump_valid is high and dump_ready is low, dump_idx/dump_data hold; valid never depends on ready.
interface cpu_debug_ctl_if
  import cpu_debug_pkg::*;
#(
  parameter int REG_WIDTH = `RegWidth,
  parameter int NUM_REGS  = `NumRegs
);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic                 dump_valid;
  logic                 dump_ready;
  logic [IDX_W-1:0]     dump_idx;
  logic [REG_WIDTH-1:0] dump_data;

  modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
  modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);

endinterface

// File: rtl/cpu_dump_scan.sv
// Snapshot bank plus index counter that streams one register per accepted transfer.
module cpu_dump_scan
  import cpu_debug_pkg::*;
#(
  parameter int REG_WIDTH = `RegWidth,
  parameter int NUM_REGS  = `NumRegs,
  parameter int IDX_W     = idx_width(NUM_REGS)
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          capture,
  input  logic                          clear,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_state,
  input  logic                          ready,
  output logic                          valid,
  output logic [IDX_W-1:0]              idx,
  output logic [REG_WIDTH-1:0]          data,
  output logic                          last_xfer
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] snap_q, snap_d;
  logic                               valid_q, valid_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;

  assign last_xfer = valid_q & ready & (idx_q == LAST_IDX);

  always_comb begin
    snap_d  = snap_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (capture) begin
      snap_d  = reg_state;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (clear) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (valid_q && ready) begin
      // The final index stays visible after the stream ends.
      if (idx_q == LAST_IDX) valid_d = 1'b0;
      else                   idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      snap_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      snap_q  <= snap_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign valid = valid_q;
  assign idx   = idx_q;
  assign data  = snap_q[idx_q];

endmodule

// File: rtl/cpu_debug_ctl.sv
// Run/halt controller with watchdog and register-dump sequencer for the CPU.
// CPU_DEBUG_DUMP_EN enables the snapshot bank and DUMP state; without it a run ends directly in DONE.
module cpu_debug_ctl
  import cpu_debug_pkg::*;
#(
  parameter int REG_WIDTH  = `RegWidth,
  parameter int NUM_REGS   = `NumRegs,
  parameter int CYC_WIDTH  = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          start,
  input  logic                          halted,
  input  logic [NUM_REGS*REG_WIDTH-1:0] reg_state,
  output logic                          run,
  output logic [CYC_WIDTH-1:0]          cycle_count,
  output logic                          done,
  output logic                          timeout,
  output dbg_state_t                    dbg_state,
  cpu_debug_ctl_if.master               dbg
);

  localparam bit                   WD_EN   = (MAX_CYCLES != 0);
  localparam logic [CYC_WIDTH-1:0] WD_LAST = CYC_WIDTH'(MAX_CYCLES - 1);
`ifdef CPU_DEBUG_DUMP_EN
  localparam dbg_state_t POST_RUN = DUMP;
`else
  localparam dbg_state_t POST_RUN = DONE;
`endif

  dbg_state_t           state_q, state_d;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic                 timeout_q, timeout_d;
  logic                 start_acc;
  logic                 leave_run;
  logic                 last_xfer;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    start_acc = 1'b0;
    leave_run = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          cyc_d     = '0;
          timeout_d = 1'b0;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        // Halt has priority over a watchdog expiry in the same cycle.
        if (halted) begin
          state_d   = POST_RUN;
          leave_run = 1'b1;
        end else if (WD_EN && (cyc_q == WD_LAST)) begin
          state_d   = POST_RUN;
          timeout_d = 1'b1;
          leave_run = 1'b1;
        end
      end
      DUMP: begin
        if (last_xfer) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign run         = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;
  assign dbg_state   = state_q;

`ifdef CPU_DEBUG_DUMP_EN
  cpu_dump_scan #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_scan (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .capture   (leave_run),
    .clear     (start_acc),
    .reg_state (reg_state),
    .ready     (dbg.dump_ready),
    .valid     (dbg.dump_valid),
    .idx       (dbg.dump_idx),
    .data      (dbg.dump_data),
    .last_xfer (last_xfer)
  );
`else
  logic unused_ok;
  assign last_xfer      = 1'b0;
  assign dbg.dump_valid = 1'b0;
  assign dbg.dump_idx   = '0;
  assign dbg.dump_data  = '0;
  assign unused_ok      = ^{reg_state, dbg.dump_ready, leave_run, start_acc};
`endif

endmodule

// File: tb/tb_cpu_debug_ctl.sv
// Self-checking bench for cpu_debug_ctl: run/halt, watchdog, saturation, restart and dump streaming.
module tb_cpu_debug_ctl;
  import cpu_debug_pkg::*;

  localparam int RW   = 16;
  localparam int NR   = 8;
  localparam int CW   = 32;
  localparam int MAXC = 20;
  localparam int IW   = idx_width(NR);
  localparam int EW   = IW + RW;
`ifdef CPU_DEBUG_DUMP_EN
  localparam int         EXP_DUMP_CYC = NR;
  localparam dbg_state_t POST_HALT    = DUMP;
  localparam logic       EXP_VALID    = 1'b1;
`else
  localparam int         EXP_DUMP_CYC = 0;
  localparam dbg_state_t POST_HALT    = DONE;
  localparam logic       EXP_VALID    = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic start = 1'b0, halted = 1'b0, ready = 1'b1;
  logic [NR*RW-1:0] reg_state = '0;
  logic run, done, timeout;
  logic [CW-1:0] cycle_count;
  dbg_state_t dbg_state;

  always #5 CLK = ~CLK;

  cpu_debug_ctl_if #(.REG_WIDTH(RW), .NUM_REGS(NR)) dbg ();
  assign dbg.dump_ready = ready;

  cpu_debug_ctl #(.REG_WIDTH(RW), .NUM_REGS(NR), .CYC_WIDTH(CW), .MAX_CYCLES(MAXC)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .halted(halted), .reg_state(reg_state),
    .run(run), .cycle_count(cycle_count), .done(done), .timeout(timeout),
    .dbg_state(dbg_state), .dbg(dbg)
  );

  // Narrow counter, watchdog disabled: exercises saturation.
  logic start_s = 1'b0, halted_s = 1'b0;
  logic run_s, done_s, timeout_s;
  logic [3:0] cyc_s;
  dbg_state_t state_s;
  cpu_debug_ctl_if #(.REG_WIDTH(RW), .NUM_REGS(NR)) dbg_s ();
  assign dbg_s.dump_ready = 1'b1;

  cpu_debug_ctl #(.REG_WIDTH(RW), .NUM_REGS(NR), .CYC_WIDTH(4), .MAX_CYCLES(0)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .start(start_s), .halted(halted_s), .reg_state(reg_state),
    .run(run_s), .cycle_count(cyc_s), .done(done_s), .timeout(timeout_s),
    .dbg_state(state_s), .dbg(dbg_s)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] e_w, o_w;

  always @(negedge CLK)
    if (RST_N && dbg.dump_valid && dbg.dump_ready)
      obs_q.push_back({dbg.dump_idx, dbg.dump_data});

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_regs_mul();
    for (int i = 0; i < NR; i++) reg_state[i*RW +: RW] = RW'(i * 'h11);
  endtask

  task automatic set_regs_rand();
    for (int i = 0; i < NR; i++) reg_state[i*RW +: RW] = RW'($urandom_range(0, 16'hFFFF));
  endtask

  // Expected stream is the register file as it stands on the halting edge.
  task automatic push_snapshot();
`ifdef CPU_DEBUG_DUMP_EN
    for (int i = 0; i < NR; i++) exp_q.push_back({IW'(i), reg_state[i*RW +: RW]});
`endif
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL reset_run: got %b want 0", run); end
    n_cmp++; if (done !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL reset_done_to: got %b%b want 00", done, timeout); end
    n_cmp++; if (cycle_count !== '0) begin n_bad++; $display("FAIL reset_cyc: got %0d want 0", cycle_count); end
    n_cmp++; if (dbg.dump_valid !== 1'b0 || dbg.dump_idx !== '0 || dbg.dump_data !== '0) begin
      n_bad++; $display("FAIL reset_dump: got v=%b i=%0d d=%h want 0/0/0", dbg.dump_valid, dbg.dump_idx, dbg.dump_data); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    int n;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (24) tick();
    n_cmp++; if (cyc_s !== 4'hF) begin n_bad++; $display("FAIL sat_cyc: got %0d want 15", cyc_s); end
    n_cmp++; if (run_s !== 1'b1) begin n_bad++; $display("FAIL sat_nowd_run: got %b want 1", run_s); end
    halted_s = 1'b1;
    tick();
    halted_s = 1'b0;
    n_cmp++; if (cyc_s !== 4'hF || timeout_s !== 1'b0 || run_s !== 1'b0) begin
      n_bad++; $display("FAIL sat_halt: got cyc=%0d to=%b run=%b want 15/0/0", cyc_s, timeout_s, run_s); end
    n = 0;
    while (done_s !== 1'b1 && n < 50) begin tick(); n++; end
    n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b want 1", done_s); end
  endtask

  task automatic test_halt10();
    int cyc;
    bit ok;
    set_regs_mul();
    pulse_start();
    n_cmp++; if (run !== 1'b1 || cycle_count !== '0 || dbg_state !== RUN) begin
      n_bad++; $display("FAIL h10_start: got run=%b cyc=%0d st=%0d want 1/0/%0d", run, cycle_count, dbg_state, RUN); end
    repeat (9) tick();
    halted = 1'b1;
    push_snapshot();
    tick();
    halted = 1'b0;
    n_cmp++; if (cycle_count !== CW'(10) || timeout !== 1'b0) begin
      n_bad++; $display("FAIL h10_cyc: got cyc=%0d to=%b want 10/0", cycle_count, timeout); end
    n_cmp++; if (run !== 1'b0 || dbg_state !== POST_HALT || dbg.dump_valid !== EXP_VALID) begin
      n_bad++; $display("FAIL h10_exit: got run=%b st=%0d v=%b want 0/%0d/%b", run, dbg_state, dbg.dump_valid, POST_HALT, EXP_VALID); end
    wait_done(cyc, ok);
    n_cmp++; if (!ok || cyc != EXP_DUMP_CYC) begin n_bad++; $display("FAIL h10_dump_len: got %0d done=%b want %0d", cyc, ok, EXP_DUMP_CYC); end
    n_cmp++; if (dbg.dump_valid !== 1'b0) begin n_bad++; $display("FAIL h10_valid_after: got %b want 0", dbg.dump_valid); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL h10_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front();
      o_w = obs_q.pop_front();
      n_cmp++; if (o_w !== e_w) begin n_bad++; $display("FAIL h10_word: got %h want %h", o_w, e_w); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_watchdog();
    int n, cyc;
    bit ok;
    set_regs_rand();
    pulse_start();
    push_snapshot();
    n = 0;
    while (run === 1'b1 && n < 100) begin n++; tick(); end
    n_cmp++; if (n != MAXC) begin n_bad++; $display("FAIL wd_run_len: got %0d want %0d", n, MAXC); end
    n_cmp++; if (cycle_count !== CW'(MAXC) || timeout !== 1'b1 || dbg_state !== POST_HALT) begin
      n_bad++; $display("FAIL wd_exit: got cyc=%0d to=%b st=%0d want %0d/1/%0d", cycle_count, timeout, dbg_state, MAXC, POST_HALT); end
    wait_done(cyc, ok);
    n_cmp++; if (!ok || cyc != EXP_DUMP_CYC) begin n_bad++; $display("FAIL wd_dump_len: got %0d done=%b want %0d", cyc, ok, EXP_DUMP_CYC); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front();
      o_w = obs_q.pop_front();
      n_cmp++; if (o_w !== e_w) begin n_bad++; $display("FAIL wd_word: got %h want %h", o_w, e_w); end
    end
    exp_q.delete();
    obs_q.delete();
    repeat (3) tick();
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b1 || cycle_count !== CW'(MAXC)) begin
      n_bad++; $display("FAIL wd_hold: got done=%b to=%b cyc=%0d want 1/1/%0d", done, timeout, cycle_count, MAXC); end
  endtask

  task automatic test_restart();
    int cyc;
    bit ok;
    set_regs_rand();
    pulse_start();
    n_cmp++; if (cycle_count !== '0 || timeout !== 1'b0 || done !== 1'b0 || run !== 1'b1) begin
      n_bad++; $display("FAIL rs_clear: got cyc=%0d to=%b done=%b run=%b want 0/0/0/1", cycle_count, timeout, done, run); end
    repeat (4) tick();
    pulse_start();
    n_cmp++; if (cycle_count !== CW'(5) || dbg_state !== RUN) begin
      n_bad++; $display("FAIL rs_start_in_run: got cyc=%0d st=%0d want 5/%0d", cycle_count, dbg_state, RUN); end
    repeat (2) tick();
    halted = 1'b1;
    push_snapshot();
    tick();
    halted = 1'b0;
    n_cmp++; if (cycle_count !== CW'(8)) begin n_bad++; $display("FAIL rs_cyc: got %0d want 8", cycle_count); end
`ifdef CPU_DEBUG_DUMP_EN
    pulse_start();
    n_cmp++; if (dbg_state !== DUMP || dbg.dump_idx !== IW'(1)) begin
      n_bad++; $display("FAIL rs_start_in_dump: got st=%0d idx=%0d want %0d/1", dbg_state, dbg.dump_idx, DUMP); end
`endif
    wait_done(cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rs_done: got %b want 1", done); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rs_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front();
      o_w = obs_q.pop_front();
      n_cmp++; if (o_w !== e_w) begin n_bad++; $display("FAIL rs_word: got %h want %h", o_w, e_w); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_halt_at_limit();
    int cyc;
    bit ok;
    set_regs_rand();
    pulse_start();
    repeat (MAXC - 1) tick();
    n_cmp++; if (cycle_count !== CW'(MAXC - 1) || run !== 1'b1) begin
      n_bad++; $display("FAIL lim_pre: got cyc=%0d run=%b want %0d/1", cycle_count, run, MAXC - 1); end
    halted = 1'b1;
    push_snapshot();
    tick();
    halted = 1'b0;
    n_cmp++; if (timeout !== 1'b0 || cycle_count !== CW'(MAXC) || dbg_state !== POST_HALT) begin
      n_bad++; $display("FAIL lim_exit: got to=%b cyc=%0d st=%0d want 0/%0d/%0d", timeout, cycle_count, dbg_state, MAXC, POST_HALT); end
    wait_done(cyc, ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL lim_count: got done=%b n=%0d want 1/%0d", ok, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front();
      o_w = obs_q.pop_front();
      n_cmp++; if (o_w !== e_w) begin n_bad++; $display("FAIL lim_word: got %h want %h", o_w, e_w); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    logic [IW-1:0] p_idx;
    logic [RW-1:0] p_data;
    logic r;
    int k;
    pat = 4'b1001;
    set_regs_rand();
    pulse_start();
    repeat (4) tick();
    halted = 1'b1;
    push_snapshot();
    tick();
    halted = 1'b0;
    set_regs_rand();
    k = 0;
    while (dbg_state === DUMP && k < 100) begin
      ready  = pat[k % 4];
      r      = ready;
      p_idx  = dbg.dump_idx;
      p_data = dbg.dump_data;
      tick();
      if (!r) begin
        n_cmp++; if (dbg.dump_idx !== p_idx || dbg.dump_data !== p_data) begin
          n_bad++; $display("FAIL bp_hold: got %0d/%h want %0d/%h", dbg.dump_idx, dbg.dump_data, p_idx, p_data); end
      end
      k++;
    end
    ready = 1'b1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", done); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front();
      o_w = obs_q.pop_front();
      n_cmp++; if (o_w !== e_w) begin n_bad++; $display("FAIL bp_word: got %h want %h", o_w, e_w); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_dump();
    int n;
    set_regs_mul();
    pulse_start();
    repeat (2) tick();
`ifdef CPU_DEBUG_DUMP_EN
    halted = 1'b1;
    tick();
    halted = 1'b0;
    n = 0;
    while (dbg.dump_idx !== IW'(3) && n < 20) begin tick(); n++; end
    n_cmp++; if (dbg.dump_idx !== IW'(3) || dbg.dump_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre: got idx=%0d v=%b want 3/1", dbg.dump_idx, dbg.dump_valid); end
`endif
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    n_cmp++; if (dbg.dump_valid !== 1'b0 || dbg_state !== IDLE || run !== 1'b0 || cycle_count !== '0) begin
      n_bad++; $display("FAIL rst_mid: got v=%b st=%0d run=%b cyc=%0d want 0/%0d/0/0", dbg.dump_valid, dbg_state, run, cycle_count, IDLE); end
    obs_q.delete();
    repeat (3) tick();
    n_cmp++; if (obs_q.size() != 0 || dbg_state !== IDLE) begin
      n_bad++; $display("FAIL rst_after: got n=%0d st=%0d want 0/%0d", obs_q.size(), dbg_state, IDLE); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_halt10();
    test_watchdog();
    test_restart();
    test_halt_at_limit();
    test_backpressure();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
